// File: rtl/adjexp_pipe_if.sv
// rtl/adjexp_pipe_if.sv - input/result handshake bundle for the exponent-adjust stage
interface adjexp_pipe_if #(
  parameter int EW = 11
);
  logic          in_valid;
  logic          in_ready;
  logic [EW-1:0] e2;
  logic          db;
  logic          sigovf;
  logic          ovf_en;
  logic          out_valid;
  logic          out_ready;
  logic [EW-1:0] e3;
  logic          ovf;

  modport slave (
    input  in_valid, e2, db, sigovf, ovf_en, out_ready,
    output in_ready, out_valid, e3, ovf
  );

  modport master (
    output in_valid, e2, db, sigovf, ovf_en, out_ready,
    input  in_ready, out_valid, e3, ovf
  );
endinterface

// File: rtl/adjexp_pipe.sv
// rtl/adjexp_pipe.sv - registered exponent adjust with overflow detect; ADJEXP_OVF_CNT_EN adds ovf_cnt
module adjexp_pipe #(
  parameter int EW   = 11,
  parameter int EWN  = 8,
  parameter int CNTW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  adjexp_pipe_if.slave      bus,
  input  logic              sticky_clr,
  output logic              ovf_sticky
`ifdef ADJEXP_OVF_CNT_EN
  ,
  output logic [CNTW-1:0]   ovf_cnt
`endif
);

  // Largest finite exponent after wrap: 2^(W-2)-1, zero-extended to EW bits
  localparam logic [EW-1:0] WRAP_W = {2'b00, {(EW-2){1'b1}}};
  localparam logic [EW-1:0] WRAP_N = {{(EW-EWN+2){1'b0}}, {(EWN-2){1'b1}}};

  logic          allones;
  logic          ovf_c;
  logic          acc;
  logic [EW-1:0] e3_c;
  logic [EW-1:0] e3_q;
  logic          ovf_q;
  logic          valid_q;
  logic          sticky_q;

  assign bus.in_ready  = ~valid_q | bus.out_ready;
  assign acc           = bus.in_valid & bus.in_ready;
  assign bus.out_valid = valid_q;
  assign bus.e3        = e3_q;
  assign bus.ovf       = ovf_q;
  assign ovf_sticky    = sticky_q;

  always_comb begin
    allones = bus.db ? (&bus.e2) : (&bus.e2[EWN-1:0]);
    ovf_c   = bus.sigovf & allones;
    e3_c    = bus.e2;
    if (ovf_c & ~bus.ovf_en) begin
      e3_c = bus.db ? WRAP_W : WRAP_N;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      e3_q    <= '0;
      ovf_q   <= 1'b0;
    end else if (acc) begin
      valid_q <= 1'b1;
      e3_q    <= e3_c;
      ovf_q   <= ovf_c;
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  // A new overflow outranks a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
    end else if (acc & ovf_c) begin
      sticky_q <= 1'b1;
    end else if (sticky_clr) begin
      sticky_q <= 1'b0;
    end
  end

`ifdef ADJEXP_OVF_CNT_EN
  logic [CNTW-1:0] cnt_q;
  assign ovf_cnt = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (sticky_clr) begin
      cnt_q <= (acc & ovf_c) ? CNTW'(1) : '0;
    end else if ((acc & ovf_c) && (cnt_q != {CNTW{1'b1}})) begin
      cnt_q <= cnt_q + CNTW'(1);
    end
  end
`else
  if (CNTW > 0) begin : g_cntw_ref
  end
`endif

endmodule
